// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory-copy DMA and its bus interface:
//   - bus width constants (32-bit address/data, 4-bit byte strobe)
//   - word-alignment mask and helper
//   - DMA controller state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Low address bits that must be zero for a word access.
    localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = 32'h0000_0003;
    localparam logic [ADDR_W-1:0] WORD_BYTES      = 32'd4;

    localparam logic [STRB_W-1:0] STRB_NONE = 4'h0;
    localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
        return (addr & WORD_ALIGN_MASK) == '0;
    endfunction

endpackage

// File: rtl/mem_copy_dma_if.sv
// -----------------------------------------------------------------------------
// mem_copy_dma_if
// picorv32-style native memory bus between the DMA (master) and a memory
// responder (slave).
//   mem_valid  master->slave  request present
//   mem_addr   master->slave  byte address (word aligned)
//   mem_wdata  master->slave  write data
//   mem_wstrb  master->slave  byte strobes; 0 = read, 4'hF = full-word write
//   mem_ready  slave->master  transfer accepted this cycle
//   mem_rdata  slave->master  read data, valid while mem_ready is high
//
// Handshake: a transfer completes on the rising clock edge where mem_valid and
// mem_ready are both high. While mem_valid is high and mem_ready is low the
// master holds mem_addr, mem_wdata and mem_wstrb constant. mem_ready while
// mem_valid is low has no meaning and is ignored by the master.
// -----------------------------------------------------------------------------
interface mem_copy_dma_if;
    import mem_bus_pkg::*;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_req_timer.sv
// -----------------------------------------------------------------------------
// mem_req_timer
// Counts cycles a bus request has been waiting for mem_ready.
//   clk      in  clock, rising edge
//   resetn   in  synchronous active-low reset
//   arm      in  request outstanding and not accepted this cycle
//   clear    in  restart the count (no request outstanding)
//   expired  out high in the TIMEOUT_CYCLES-th consecutive armed cycle
// TIMEOUT_CYCLES = 0 disables the timer (expired stays low).
// -----------------------------------------------------------------------------
module mem_req_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic arm,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_cnt;

            // r_cnt holds the number of armed cycles already elapsed, so the
            // N-th armed cycle sees r_cnt == N-1.
            always_ff @(posedge clk) begin
                if (!resetn || clear) begin
                    r_cnt <= '0;
                end else if (arm && (r_cnt != LAST)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign expired = arm && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
// Word-granular memory copy / fill engine driving a picorv32 native bus.
// Copy mode alternates one read and one write per word; fill mode issues
// writes of fill_value only.
//
// Ports
//   clk, resetn        clock (rising edge), synchronous active-low reset
//   start              one-cycle command pulse, accepted only when idle
//   src_addr/dst_addr  byte addresses, must be word aligned (src only in copy)
//   len_words          number of words to move (0 = complete immediately)
//   fill_mode          1: write fill_value, 0: copy from source
//   fill_value         fill data
//   mem                bus master port (see mem_copy_dma_if)
//   busy               high in RD, WR and DONE
//   done               one-cycle pulse following the DONE state
//   err                sticky: misaligned command or bus timeout
//   words_done         writes completed for the current command
//   dbg_state          current controller state
// -----------------------------------------------------------------------------
module mem_copy_dma
    import mem_bus_pkg::*;
#(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len_words,
    input  logic                 fill_mode,
    input  logic [DATA_W-1:0]    fill_value,
    mem_copy_dma_if.master       mem,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_W-1:0]     words_done,
    output logic [1:0]           dbg_state
);

    dma_state_e        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_fill_mode;
    logic [DATA_W-1:0] r_fill_value;
    logic [DATA_W-1:0] r_rdata;

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic              r_done;
    logic              r_err;
    logic [LEN_W-1:0]  r_words_done;

    logic              w_fire;
    logic              w_expired;
    logic              w_timeout;
    logic              w_misaligned;
    logic              w_last_write;

    assign w_fire       = r_valid && mem.mem_ready;
    assign w_timeout    = r_valid && !mem.mem_ready && w_expired;
    // Source alignment is irrelevant in fill mode since it is never read.
    assign w_misaligned = !is_word_aligned(dst_addr) ||
                          (!fill_mode && !is_word_aligned(src_addr));
    assign w_last_write = (r_remaining == LEN_W'(1));

    mem_req_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .arm     (r_valid && !mem.mem_ready),
        .clear   (!r_valid),
        .expired (w_expired)
    );

    // Each RD/WR visit starts with mem_valid low: the first cycle in the state
    // loads the bus fields and raises mem_valid, which yields exactly one idle
    // bus cycle after every completed transfer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_remaining  <= '0;
            r_fill_mode  <= 1'b0;
            r_fill_value <= '0;
            r_rdata      <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_words_done <= '0;
        end else begin
            r_done <= (r_state == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_remaining  <= len_words;
                        r_fill_mode  <= fill_mode;
                        r_fill_value <= fill_value;
                        r_err        <= w_misaligned;
                        r_words_done <= '0;
                        r_valid      <= 1'b0;
                        if (w_misaligned || (len_words == '0)) begin
                            r_state <= ST_DONE;
                        end else if (fill_mode) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_addr  <= r_src;
                        r_wdata <= '0;
                        r_wstrb <= STRB_NONE;
                    end else if (w_fire) begin
                        r_valid <= 1'b0;
                        r_rdata <= mem.mem_rdata;
                        r_src   <= r_src + WORD_BYTES;
                        r_state <= ST_WR;
                    end else if (w_timeout) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_WR: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_addr  <= r_dst;
                        r_wdata <= r_fill_mode ? r_fill_value : r_rdata;
                        r_wstrb <= STRB_FULL;
                    end else if (w_fire) begin
                        r_valid      <= 1'b0;
                        r_dst        <= r_dst + WORD_BYTES;
                        r_words_done <= r_words_done + 1'b1;
                        r_remaining  <= r_remaining - 1'b1;
                        if (w_last_write) begin
                            r_state <= ST_DONE;
                        end else if (r_fill_mode) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end else if (w_timeout) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_valid = r_valid;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_wstrb = r_wstrb;

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign words_done = r_words_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_copy_dma.sv
`timescale 1ns/1ps
module tb_mem_copy_dma;
    import mem_bus_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        fill_mode;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_done;
    logic [1:0]  dbg_state;

    mem_copy_dma_if bus();

    mem_copy_dma #(
        .LEN_W          (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic        tx_we   [$];
    logic [31:0] tx_addr [$];
    logic [31:0] tx_data [$];
    logic [3:0]  tx_strb [$];
    logic [31:0] exp_q   [$];

    int ready_delay  = 0;
    int never_ready  = 0;
    int stray_ready  = 0;
    int stab_err     = 0;
    int gap_err      = 0;
    int last_run     = 0;
    int wr_cnt       = 0;
    int done_cnt     = 0;
    int seen_fire    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- responder / bus monitor ----------------
    initial begin : responder
        int          cyc;
        int          wait_cnt;
        int          run_len;
        int          last_fire_cyc;
        logic        prev_valid;
        logic        prev_fire;
        logic        fire;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic [3:0]  h_wstrb;
        cyc = 0; wait_cnt = 0; run_len = 0; last_fire_cyc = 0;
        prev_valid = 1'b0; prev_fire = 1'b0;
        h_addr = '0; h_wdata = '0; h_wstrb = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.mem_valid === 1'b1 && prev_valid && !prev_fire) begin
                if (bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata || bus.mem_wstrb !== h_wstrb)
                    stab_err++;
            end
            if (bus.mem_valid === 1'b1 && prev_fire) gap_err++;
            if (bus.mem_valid === 1'b1 && !prev_valid && seen_fire != 0 && (cyc - last_fire_cyc) != 2)
                gap_err++;
            if (bus.mem_valid === 1'b1) begin
                run_len++;
            end else if (prev_valid) begin
                last_run = run_len;
                run_len  = 0;
            end
            fire = 1'b0;
            if (bus.mem_valid === 1'b1) begin
                wait_cnt++;
                if (never_ready == 0 && wait_cnt > ready_delay) begin
                    fire = 1'b1;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_wstrb == 4'h0) begin
                        bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
                        tx_data.push_back(bus.mem_rdata);
                    end else begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                        tx_data.push_back(bus.mem_wdata);
                        wr_cnt++;
                    end
                    tx_we.push_back(bus.mem_wstrb != 4'h0);
                    tx_addr.push_back(bus.mem_addr);
                    tx_strb.push_back(bus.mem_wstrb);
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end else begin
                wait_cnt = 0;
                bus.mem_ready = (stray_ready != 0);
                bus.mem_rdata = 32'hBAD0_BAD0;
            end
            if (fire) begin
                last_fire_cyc = cyc;
                seen_fire     = 1;
            end
            prev_valid = (bus.mem_valid === 1'b1);
            prev_fire  = fire;
            h_addr  = bus.mem_addr;
            h_wdata = bus.mem_wdata;
            h_wstrb = bus.mem_wstrb;
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        tx_we.delete(); tx_addr.delete(); tx_data.delete(); tx_strb.delete();
        exp_q.delete();
        stab_err = 0; gap_err = 0; seen_fire = 0; wr_cnt = 0;
    endtask

    task automatic start_job(input logic fm, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] n, input logic [31:0] fv);
        fill_mode  = fm;
        src_addr   = s;
        dst_addr   = d;
        len_words  = n;
        fill_value = fv;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), 32'(done), 32'd0);
    endtask

    // Pops expected write data and compares against logged writes in order.
    task automatic check_writes(input string tag);
        logic [31:0] e;
        for (int i = 0; i < tx_we.size(); i++) begin
            if (tx_we[i]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                check($sformatf("%s_wdata%0d", tag, i), tx_data[i], e);
                check($sformatf("%s_wstrb%0d", tag, i), 32'(tx_strb[i]), 32'h0000_000F);
            end
        end
        check($sformatf("%s_exp_left", tag), 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] src_vals [4];
    logic [31:0] rst_vals [4];

    initial begin : main
        int dc0;
        int found;
        resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0;
        len_words = '0; fill_mode = 1'b0; fill_value = '0;
        src_vals[0] = 32'h1111_0001; src_vals[1] = 32'h2222_0002;
        src_vals[2] = 32'h3333_0003; src_vals[3] = 32'h4444_0004;
        rst_vals[0] = 32'h6000_0000; rst_vals[1] = 32'h6000_0001;
        rst_vals[2] = 32'h6000_0002; rst_vals[3] = 32'h6000_0003;

        // Reset state
        tick(3);
        check("rst_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_addr",  bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_words", 32'(words_done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        resetn = 1'b1;
        tick(2);

        // Copy 4 words 0x100 -> 0x200, ready on the first valid cycle
        for (int i = 0; i < 4; i++) mem_model[32'h100 + 32'(4*i)] = src_vals[i];
        clear_log();
        dc0 = done_cnt;
        start_job(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
        check("copy_busy", 32'(busy), 32'd1);
        wait_done("copy");
        check("copy_tx_count", 32'(tx_we.size()), 32'd8);
        for (int i = 0; i < 8 && i < tx_we.size(); i++) begin
            check($sformatf("copy_we%0d", i), 32'(tx_we[i]), 32'(i % 2));
            check($sformatf("copy_addr%0d", i), tx_addr[i],
                  ((i % 2) == 0 ? 32'h100 : 32'h200) + 32'(4 * (i / 2)));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(src_vals[i]);
        check_writes("copy");
        for (int i = 0; i < 4; i++)
            check($sformatf("copy_mem%0d", i), mem_model[32'h200 + 32'(4*i)], src_vals[i]);
        check("copy_words", 32'(words_done), 32'd4);
        check("copy_err", 32'(err), 32'd0);
        check("copy_done_cnt", 32'(done_cnt - dc0), 32'd1);
        check("copy_gap", 32'(gap_err), 32'd0);

        // Fill 3 words at 0x40; src misaligned but unused; stray ready while idle
        clear_log();
        stray_ready = 1;
        start_job(1'b1, 32'h0000_0003, 32'h40, 16'd3, 32'hDEAD_BEEF);
        wait_done("fill");
        stray_ready = 0;
        check("fill_tx_count", 32'(tx_we.size()), 32'd3);
        for (int i = 0; i < 3 && i < tx_we.size(); i++) begin
            check($sformatf("fill_we%0d", i), 32'(tx_we[i]), 32'd1);
            check($sformatf("fill_addr%0d", i), tx_addr[i], 32'h40 + 32'(4*i));
            exp_q.push_back(32'hDEAD_BEEF);
        end
        check_writes("fill");
        check("fill_gap", 32'(gap_err), 32'd0);
        check("fill_err", 32'(err), 32'd0);
        check("fill_words", 32'(words_done), 32'd3);

        // Backpressure: ready after 5 waiting cycles; a start while busy is ignored
        mem_model[32'h300] = 32'hCAFE_0001;
        mem_model[32'h304] = 32'hCAFE_0002;
        clear_log();
        ready_delay = 5;
        start_job(1'b0, 32'h300, 32'h380, 16'd2, 32'h0);
        tick(3);
        start_job(1'b1, 32'h900, 32'h904, 16'd7, 32'h5555_5555);
        wait_done("bp");
        ready_delay = 0;
        check("bp_tx_count", 32'(tx_we.size()), 32'd4);
        if (tx_addr.size() == 4) begin
            check("bp_addr0", tx_addr[0], 32'h300);
            check("bp_addr1", tx_addr[1], 32'h380);
            check("bp_addr2", tx_addr[2], 32'h304);
            check("bp_addr3", tx_addr[3], 32'h384);
        end
        check("bp_stable", 32'(stab_err), 32'd0);
        check("bp_gap", 32'(gap_err), 32'd0);
        check("bp_valid_len", 32'(last_run), 32'd6);
        check("bp_mem0", mem_model[32'h380], 32'hCAFE_0001);
        check("bp_mem1", mem_model[32'h384], 32'hCAFE_0002);
        check("bp_ignored_start", 32'(mem_model.exists(32'h904)), 32'd0);
        check("bp_words", 32'(words_done), 32'd2);

        // Timeout: ready never comes, timer set to 8 cycles
        clear_log();
        never_ready = 1;
        dc0 = done_cnt;
        start_job(1'b1, 32'h0, 32'h500, 16'd3, 32'h1234_5678);
        wait_done("tmo");
        never_ready = 0;
        check("tmo_valid_len", 32'(last_run), 32'd8);
        check("tmo_valid_low", 32'(bus.mem_valid), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_words", 32'(words_done), 32'd0);
        check("tmo_tx_count", 32'(tx_we.size()), 32'd0);
        check("tmo_done_cnt", 32'(done_cnt - dc0), 32'd1);

        // len = 0: done two cycles after start, no traffic, err cleared by start
        clear_log();
        start_job(1'b0, 32'h100, 32'h200, 16'd0, 32'h0);
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_err_cleared", 32'(err), 32'd0);
        check("len0_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("len0_done_low", 32'(done), 32'd0);
        check("len0_tx_count", 32'(tx_we.size()), 32'd0);
        check("len0_err", 32'(err), 32'd0);

        // Misaligned destination
        clear_log();
        start_job(1'b0, 32'h100, 32'h202, 16'd4, 32'h0);
        wait_done("dstmis");
        check("dstmis_err", 32'(err), 32'd1);
        check("dstmis_tx_count", 32'(tx_we.size()), 32'd0);
        check("dstmis_words", 32'(words_done), 32'd0);

        // Misaligned source in copy mode
        clear_log();
        start_job(1'b0, 32'h102, 32'h200, 16'd1, 32'h0);
        wait_done("srcmis");
        check("srcmis_err", 32'(err), 32'd1);
        check("srcmis_tx_count", 32'(tx_we.size()), 32'd0);

        // Destination pointer wraps past 0xFFFF_FFFC
        clear_log();
        start_job(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678);
        wait_done("wrap");
        check("wrap_tx_count", 32'(tx_we.size()), 32'd2);
        if (tx_addr.size() == 2) begin
            check("wrap_addr0", tx_addr[0], 32'hFFFF_FFFC);
            check("wrap_addr1", tx_addr[1], 32'h0000_0000);
        end
        check("wrap_err", 32'(err), 32'd0);
        check("wrap_words", 32'(words_done), 32'd2);

        // Reset during the second write of a 4-word copy
        for (int i = 0; i < 4; i++) mem_model[32'h600 + 32'(4*i)] = rst_vals[i];
        clear_log();
        ready_delay = 3;
        start_job(1'b0, 32'h600, 32'h700, 16'd4, 32'h0);
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.mem_valid === 1'b1 && bus.mem_wstrb === 4'hF && wr_cnt == 1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_2nd_write", 32'(found), 32'd1);
        resetn = 1'b0;
        dc0 = done_cnt;
        @(negedge clk);
        check("midrst_valid", 32'(bus.mem_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", bus.mem_addr, 32'd0);
        check("midrst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("midrst_words", 32'(words_done), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ready_delay = 0;
        tick(4);
        check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        clear_log();
        start_job(1'b0, 32'h600, 32'h780, 16'd4, 32'h0);
        wait_done("postrst");
        check("postrst_tx_count", 32'(tx_we.size()), 32'd8);
        for (int i = 0; i < 4; i++) exp_q.push_back(rst_vals[i]);
        check_writes("postrst");
        for (int i = 0; i < 4; i++)
            check($sformatf("postrst_mem%0d", i), mem_model[32'h780 + 32'(4*i)], rst_vals[i]);
        check("postrst_words", 32'(words_done), 32'd4);
        check("postrst_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
